mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer.sv | 119 +++++++++++
 tb/tb_mem_access_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: load/store/swap control sequencer with alignment and MFC-timeout traps
module mem_access_sequencer #(
  parameter int RIDX_W      = 5,
  parameter int TO_CYCLES   = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              Clk,
  input  logic              RESET_n,
  input  logic              start,
  input  logic [5:0]        op,
  input  logic [RIDX_W-1:0] rd,
  input  logic [2:0]        addr_lo,
  input  logic              MFC,
  output logic              busy,
  output logic              done,
  output logic              trap,
  output logic [1:0]        trap_code,
  output logic              MAR_Enable,
  output logic              MDR_Enable,
  output logic              MDR_Mux_select,
  output logic              RAM_enable,
  output logic              TEMP_Enable,
  output logic              register_file,
  output logic [5:0]        RAM_OpCode,
  output logic [RIDX_W-1:0] rf_sel,
  output logic              addr_inc,
  output logic              wb_temp
);
  typedef enum logic [3:0] {IDLE, ADDR, RREQ, TEMP, DLOAD, WREQ, WB, DONE, TRAP} state_t;
  state_t state, state_n;
  logic [5:0] op_q;
  logic [RIDX_W-1:0] rd_q;
  logic [2:0] alo_q;
  logic word2, word2_n;
  logic [7:0] wcnt;
  logic [1:0] tcode_n;
  logic [5:0] op_c;
  logic [RIDX_W-1:0] rd_c;
  logic [2:0] alo_c;
  logic is_ld, is_st, is_sw, is_dbl, is_half, is_word, legal, mis, last, tmo, in_req;
  // In IDLE the decode looks at the live inputs so a bad access can trap straight from the start edge
  assign op_c    = (state == IDLE) ? op : op_q;
  assign rd_c    = (state == IDLE) ? rd : rd_q;
  assign alo_c   = (state == IDLE) ? addr_lo : alo_q;
  assign is_ld   = op_c inside {6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010, 6'b000011};
  assign is_st   = op_c inside {6'b000100, 6'b000101, 6'b000110, 6'b000111};
  assign is_sw   = op_c == 6'b001111;
  assign is_dbl  = op_c inside {6'b000011, 6'b000111};
  assign is_half = op_c inside {6'b000010, 6'b001010, 6'b000110};
  assign is_word = op_c inside {6'b000000, 6'b000100};
  assign legal   = is_ld || is_st || is_sw;
  assign mis     = (ALIGN_CHECK != 0) && (((is_word || is_sw) && alo_c[1:0] != 2'b00) ||
                   (is_half && alo_c[0]) || (is_dbl && (alo_c != 3'b000 || rd_c[0])));
  assign last    = !is_dbl || word2;
  assign in_req  = state == RREQ || state == WREQ;
  assign tmo     = wcnt == 8'(TO_CYCLES - 1);
  assign word2_n = (state == IDLE) ? 1'b0 : (state_n == ADDR) ? 1'b1 : word2;
  // State register, latched access fields, request wait counter and sticky trap code
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      alo_q     <= '0;
      word2     <= 1'b0;
      wcnt      <= '0;
      trap_code <= 2'b00;
    end else begin
      state <= state_n;
      word2 <= word2_n;
      wcnt  <= (in_req && !MFC && state_n == state) ? wcnt + 8'd1 : 8'd0;
      if (state == IDLE && start) begin
        op_q  <= op;
        rd_q  <= rd;
        alo_q <= addr_lo;
      end
      if (state_n == TRAP) trap_code <= tcode_n;
    end
  end
  // Next-state selection; a double access loops back to ADDR once before finishing
  always_comb begin
    state_n = state;
    tcode_n = 2'b00;
    case (state)
      IDLE: if (start) begin
        state_n = (!legal || mis) ? TRAP : ADDR;
        tcode_n = !legal ? 2'b01 : 2'b10;
      end
      ADDR:  state_n = is_st ? DLOAD : RREQ;
      RREQ:  if (MFC) state_n = is_sw ? TEMP : WB;
             else if (tmo) begin
               state_n = TRAP;
               tcode_n = 2'b11;
             end
      TEMP:  state_n = DLOAD;
      DLOAD: state_n = WREQ;
      WREQ:  if (MFC) state_n = is_sw ? WB : last ? DONE : ADDR;
             else if (tmo) begin
               state_n = TRAP;
               tcode_n = 2'b11;
             end
      WB:    state_n = last ? DONE : ADDR;
      default: state_n = IDLE;
    endcase
  end
  assign busy           = state != IDLE;
  assign MAR_Enable     = state == ADDR;
  assign addr_inc       = state == ADDR && word2;
  assign RAM_enable     = in_req;
  assign MDR_Mux_select = state == RREQ;
  assign MDR_Enable     = (state == RREQ && MFC) || state == DLOAD;
  assign TEMP_Enable    = state == TEMP;
  assign register_file  = state == WB;
  assign wb_temp        = state == WB && is_sw;
  assign done           = state == DONE;
  assign trap           = state == TRAP;
  assign RAM_OpCode     = RAM_enable ? op_q : 6'b000000;
  assign rf_sel         = (state == DLOAD || state == WB) ? (word2 ? {rd_q[RIDX_W-1:1], 1'b1} : rd_q) : '0;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed stimulus with a completion scoreboard and per-cycle strobe checks
module tb_mem_access_sequencer;
  logic Clk = 0, RESET_n = 0, start = 0, MFC = 0;
  logic [5:0] op = 0;
  logic [4:0] rd = 0;
  logic [2:0] addr_lo = 0;
  logic busy, done, trap, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, TEMP_Enable;
  logic register_file, addr_inc, wb_temp;
  logic [1:0] trap_code;
  logic [5:0] RAM_OpCode;
  logic [4:0] rf_sel;
  logic [10:0] sig;
  int n_vec = 0, n_bad = 0, cyc = 0, t_start = 0;
  typedef struct {bit tr; int code; int lat;} exp_t;
  exp_t q[$];
  localparam logic [10:0] B = 11'h400, MAR = 11'h200, MDE = 11'h100, MUX = 11'h080, RAM = 11'h040,
    TMP = 11'h020, RF = 11'h010, INC = 11'h008, WBT = 11'h004, DN = 11'h002, TR = 11'h001;

  mem_access_sequencer dut (
    .Clk(Clk), .RESET_n(RESET_n), .start(start), .op(op), .rd(rd), .addr_lo(addr_lo), .MFC(MFC),
    .busy(busy), .done(done), .trap(trap), .trap_code(trap_code), .MAR_Enable(MAR_Enable),
    .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select), .RAM_enable(RAM_enable),
    .TEMP_Enable(TEMP_Enable), .register_file(register_file), .RAM_OpCode(RAM_OpCode),
    .rf_sel(rf_sel), .addr_inc(addr_inc), .wb_temp(wb_temp)
  );

  assign sig = {busy, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, TEMP_Enable,
                register_file, addr_inc, wb_temp, done, trap};

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Completion monitor: every done/trap pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (RESET_n && (done || trap)) begin
      if (q.size() == 0) chk("sb spurious completion", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb kind", int'(trap), int'(e.tr));
        if (e.tr) chk("sb trap_code", int'(trap_code), e.code);
        chk("sb latency", cyc - t_start + 1, e.lat);
      end
    end
  end

  task automatic issue(logic [5:0] o, logic [4:0] r, logic [2:0] a, bit tr, int code, int lat);
    if (lat > 0) q.push_back('{tr, code, lat});
    op = o; rd = r; addr_lo = a; start = 1;
    @(posedge Clk); #1;
    t_start = cyc;
    start = 0;
  endtask

  task automatic cc(string nm, logic m, logic [10:0] es, int rf = -1, int opc = -1);
    MFC = m;
    @(negedge Clk);
    chk({nm, " strobes"}, int'(sig), int'(es));
    if (rf >= 0) chk({nm, " rf_sel"}, int'(rf_sel), rf);
    if (opc >= 0) chk({nm, " RAM_OpCode"}, int'(RAM_OpCode), opc);
    @(posedge Clk); #1;
  endtask

  initial begin
    #12;
    chk("reset strobes", int'(sig), 0);
    chk("reset trap_code", int'(trap_code), 0);
    @(posedge Clk); #1;
    RESET_n = 1;
    // LD rd=3, MFC tied high
    issue(6'b000000, 5'd3, 3'b000, 0, 0, 4);
    cc("ld addr", 1, B | MAR);
    cc("ld rreq", 1, B | RAM | MUX | MDE, -1, 0);
    cc("ld wb", 1, B | RF, 3);
    cc("ld done", 1, B | DN);
    cc("ld idle", 1, 0);
    // STD rd=4, MFC two cycles late on each write request
    issue(6'b000111, 5'd4, 3'b000, 0, 0, 11);
    for (int w = 0; w < 2; w++) begin
      cc($sformatf("std addr%0d", w), 0, w ? (B | MAR | INC) : (B | MAR));
      cc($sformatf("std dload%0d", w), 0, B | MDE, 4 + w);
      for (int i = 0; i < 3; i++) cc($sformatf("std wreq%0d.%0d", w, i), i == 2, B | RAM, -1, 7);
    end
    cc("std done", 0, B | DN);
    cc("std idle", 0, 0);
    // SWAP rd=7
    issue(6'b001111, 5'd7, 3'b000, 0, 0, 7);
    cc("swap addr", 1, B | MAR);
    cc("swap rreq", 1, B | RAM | MUX | MDE, -1, 6'b001111);
    cc("swap temp", 1, B | TMP);
    cc("swap dload", 1, B | MDE, 7);
    cc("swap wreq", 1, B | RAM);
    cc("swap wb", 1, B | RF | WBT, 7);
    cc("swap done", 1, B | DN);
    // LDD rd=2 then ST rd=1, zero-wait
    issue(6'b000011, 5'd2, 3'b000, 0, 0, 7);
    cc("ldd addr0", 1, B | MAR);
    cc("ldd rreq0", 1, B | RAM | MUX | MDE);
    cc("ldd wb0", 1, B | RF, 2);
    cc("ldd addr1", 1, B | MAR | INC);
    cc("ldd rreq1", 1, B | RAM | MUX | MDE);
    cc("ldd wb1", 1, B | RF, 3);
    cc("ldd done", 1, B | DN);
    issue(6'b000100, 5'd1, 3'b100, 0, 0, 4);
    cc("st addr", 1, B | MAR);
    cc("st dload", 1, B | MDE, 1);
    cc("st wreq", 1, B | RAM, -1, 4);
    cc("st done", 1, B | DN);
    // Immediate traps
    issue(6'b000010, 5'd0, 3'b001, 1, 2, 1);
    cc("lduh trap", 0, B | TR);
    cc("lduh idle", 0, 0);
    chk("lduh code held", int'(trap_code), 2);
    issue(6'b111111, 5'd0, 3'b000, 1, 1, 1);
    cc("illegal trap", 0, B | TR);
    issue(6'b000011, 5'd5, 3'b000, 1, 2, 1);
    cc("ldd odd trap", 0, B | TR);
    issue(6'b000100, 5'd0, 3'b010, 1, 2, 1);
    cc("st mis trap", 0, B | TR);
    // LD timeout: MFC never arrives
    issue(6'b000000, 5'd6, 3'b000, 1, 3, 18);
    cc("to addr", 0, B | MAR);
    for (int i = 0; i < 16; i++) cc($sformatf("to rreq%0d", i), 0, B | RAM | MUX);
    cc("to trap", 0, B | TR);
    cc("to idle", 0, 0);
    // LD with MFC on the 16th request cycle: completes, old trap code persists
    issue(6'b000000, 5'd6, 3'b000, 0, 0, 19);
    cc("late addr", 0, B | MAR);
    for (int i = 0; i < 15; i++) cc($sformatf("late rreq%0d", i), 0, B | RAM | MUX);
    cc("late rreq15", 1, B | RAM | MUX | MDE);
    cc("late wb", 0, B | RF, 6);
    cc("late done", 0, B | DN);
    chk("late code held", int'(trap_code), 3);
    // Reset in the middle of a STD write request
    issue(6'b000111, 5'd4, 3'b000, 0, 0, 0);
    cc("rst addr", 0, B | MAR);
    cc("rst dload", 0, B | MDE, 4);
    cc("rst wreq", 0, B | RAM);
    RESET_n = 0;
    #1;
    chk("rst strobes", int'(sig), 0);
    chk("rst trap_code", int'(trap_code), 0);
    chk("rst RAM_OpCode", int'(RAM_OpCode), 0);
    @(posedge Clk); #1;
    RESET_n = 1;
    // LD after release, with an illegal start pulsed while busy
    issue(6'b000000, 5'd9, 3'b000, 0, 0, 4);
    cc("post addr", 1, B | MAR);
    start = 1; op = 6'b111111;
    cc("post rreq", 1, B | RAM | MUX | MDE, -1, 0);
    start = 0;
    cc("post wb", 1, B | RF, 9);
    cc("post done", 1, B | DN);
    cc("post idle", 1, 0);
    cc("post idle2", 1, 0);
    chk("sb drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
